keypad_scan_sequencer: RTL and testbench

//  Scans the 4x4 keypad matrix (rows driven active-low, columns read active-low).

---
 rtl/keypad_scan_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_sequencer.sv
`timescale 1ns/1ps
// keypad_scan_sequencer
//   Scans a 4x4 active-low keypad matrix one row at a time, debounces all
//   16 keys into a stable key map and queues press/release events in a small
//   FIFO read out through a valid/ready handshake.
//
//   State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | scanning halted, rows released (kp_row = 4'b1111)
//   S_DRIVE  | current row driven low, waiting SETTLE_CYC cycles
//   S_SAMPLE | columns captured into samp_col
//   S_EVAL   | one column per cycle is debounced (col = 0..3)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   enable     1 = scanning runs, 0 = scanning halted
//   kp_col     column inputs, 0 = key closed on the driven row
//   kp_row     row drive, one bit low while scanning
//   key_state  debounced key map, bit k = key code k held
//   ev_valid   event FIFO non-empty
//   ev_data    {press, key code} at FIFO head
//   ev_ready   consumer accepts head when ev_valid & ev_ready
//   frame_tick one-cycle pulse after row 3 evaluation completes
//   overflow   sticky, an event was dropped on a full FIFO
module keypad_scan_sequencer #(
  parameter int SETTLE_CYC     = 2,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  kp_col,
  output logic [3:0]  kp_row,
  output logic [15:0] key_state,
  output logic        ev_valid,
  output logic [4:0]  ev_data,
  input  logic        ev_ready,
  output logic        frame_tick,
  output logic        overflow
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_EVAL} state_t;

  state_t        state;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [SW-1:0] settle;
  logic [3:0]    samp_col;
  logic [2:0]    deb_cnt [16];

  // Physical position to key code; col index i corresponds to kp_col[i].
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd7;   4'h1: key_code = 4'd4;
      4'h2: key_code = 4'd1;   4'h3: key_code = 4'd0;
      4'h4: key_code = 4'd8;   4'h5: key_code = 4'd5;
      4'h6: key_code = 4'd2;   4'h7: key_code = 4'd10;
      4'h8: key_code = 4'd9;   4'h9: key_code = 4'd6;
      4'hA: key_code = 4'd3;   4'hB: key_code = 4'd11;
      4'hC: key_code = 4'd12;  4'hD: key_code = 4'd13;
      4'hE: key_code = 4'd14;  default: key_code = 4'd15;
    endcase
  endfunction

  logic [3:0] cur_key;
  logic       raw;
  logic       differ;
  logic [2:0] cnt_inc;
  logic       push;
  logic [1:0] next_row;

  assign cur_key  = key_code(row, col);
  assign raw      = ~samp_col[col];
  assign differ   = (raw != key_state[cur_key]);
  assign cnt_inc  = deb_cnt[cur_key] + 3'd1;
  assign next_row = row + 2'd1;
  // Only one key is evaluated per cycle, so at most one push per cycle.
  assign push     = enable && (state == S_EVAL) && differ &&
                    (cnt_inc == 3'(DEBOUNCE_SCANS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      row        <= 2'd0;
      col        <= 2'd0;
      settle     <= '0;
      samp_col   <= 4'hF;
      kp_row     <= 4'hF;
      key_state  <= '0;
      frame_tick <= 1'b0;
      for (int i = 0; i < 16; i++) deb_cnt[i] <= 3'd0;
    end else if (!enable) begin
      // Abandon any partial frame; key map is kept, history is not.
      state      <= S_IDLE;
      kp_row     <= 4'hF;
      frame_tick <= 1'b0;
      for (int i = 0; i < 16; i++) deb_cnt[i] <= 3'd0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          state  <= S_DRIVE;
          row    <= 2'd0;
          kp_row <= 4'b1110;
          settle <= SW'(SETTLE_CYC - 1);
        end
        S_DRIVE: begin
          if (settle == '0) state <= S_SAMPLE;
          else              settle <= settle - 1'b1;
        end
        S_SAMPLE: begin
          samp_col <= kp_col;
          col      <= 2'd0;
          state    <= S_EVAL;
        end
        S_EVAL: begin
          if (!differ) begin
            deb_cnt[cur_key] <= 3'd0;
          end else if (cnt_inc == 3'(DEBOUNCE_SCANS)) begin
            key_state[cur_key] <= raw;
            deb_cnt[cur_key]   <= 3'd0;
          end else begin
            deb_cnt[cur_key] <= cnt_inc;
          end
          if (col == 2'd3) begin
            row        <= next_row;
            kp_row     <= ~(4'b0001 << next_row);
            settle     <= SW'(SETTLE_CYC - 1);
            state      <= S_DRIVE;
            frame_tick <= (row == 2'd3);
          end else begin
            col <= col + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Event FIFO
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          accept;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept   = push && (!full || pop);
  assign ev_data  = ev_valid ? mem[rd_ptr] : 5'd0;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {raw, cur_key};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
`timescale 1ns/1ps
// tb_keypad_scan_sequencer
//   Directed scenarios plus a randomized run, checked every cycle against a
//   frame-position model of the scanner (position 0..27 within a frame,
//   dwell of 7 cycles per row) and an event queue.
module tb_keypad_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  kp_col;
  logic [3:0]  kp_row;
  logic [15:0] key_state;
  logic        ev_valid;
  logic [4:0]  ev_data;
  logic        ev_ready;
  logic        frame_tick;
  logic        overflow;

  keypad_scan_sequencer #(.SETTLE_CYC(2), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .kp_col(kp_col), .kp_row(kp_row),
    .key_state(key_state), .ev_valid(ev_valid), .ev_data(ev_data),
    .ev_ready(ev_ready), .frame_tick(frame_tick), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Physical keypad: which keys are closed, and the matrix wiring.
  int keymap [4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{12, 13, 14, 15}};
  bit [15:0] pressed;

  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp_row[r] && pressed[keymap[r][c]]) kp_col[c] = 1'b0;
  end

  // Behavioural model
  bit          m_scan;
  int          m_pos;
  bit          m_tick;
  bit          m_ovf;
  logic [15:0] m_ks;
  int          m_cnt [16];
  bit          m_snap [4];
  logic [4:0]  mq [$];

  always @(posedge clk or negedge rst) begin
    int r, s, c, k;
    bit pop_ok, was_full, push_b;
    logic [4:0] pv;
    if (!rst) begin
      m_scan = 0; m_pos = 0; m_tick = 0; m_ovf = 0; m_ks = '0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      mq.delete();
    end else begin
      pop_ok   = (mq.size() != 0) && ev_ready;
      was_full = (mq.size() == 4);
      push_b   = 0;
      pv       = '0;
      m_tick   = 0;
      if (!enable) begin
        m_scan = 0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      end else if (!m_scan) begin
        m_scan = 1;
        m_pos  = 0;
      end else begin
        r = m_pos / 7;
        s = m_pos % 7;
        if (s == 2)
          for (int j = 0; j < 4; j++) m_snap[j] = pressed[keymap[r][j]];
        if (s >= 3) begin
          c = s - 3;
          k = keymap[r][c];
          if (m_snap[c] == m_ks[k]) m_cnt[k] = 0;
          else begin
            m_cnt[k]++;
            if (m_cnt[k] == 3) begin
              m_ks[k]  = m_snap[c];
              m_cnt[k] = 0;
              push_b   = 1;
              pv       = {m_snap[c], 4'(k)};
            end
          end
        end
        if (m_pos == 27) m_tick = 1;
        m_pos = (m_pos + 1) % 28;
      end
      if (pop_ok) void'(mq.pop_front());
      if (push_b) begin
        if (!was_full || pop_ok) mq.push_back(pv);
        else m_ovf = 1;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    logic [3:0] er;
    er = 4'hF;
    if (m_scan) er[m_pos / 7] = 1'b0;
    check("kp_row", kp_row, er);
    check("key_state", key_state, m_ks);
    check("ev_valid", ev_valid, mq.size() != 0);
    if (mq.size() != 0) check("ev_data", ev_data, mq[0]);
    check("frame_tick", frame_tick, m_tick);
    check("overflow", overflow, m_ovf);
  end

  int edge_cnt;
  int ev_seen;
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt = 0;
    else begin
      edge_cnt++;
      if (ev_valid && ev_ready) ev_seen++;
    end
  end

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (edge_cnt != n) begin
      failures++;
      $display("FAIL wait_edge: at edge %0d wanted %0d", edge_cnt, n);
    end
  endtask

  task automatic check_reset_values();
    check("rst_kp_row", kp_row, 4'hF);
    check("rst_key_state", key_state, 16'h0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_data", ev_data, 5'd0);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_overflow", overflow, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    rst = 0; enable = 1; ev_ready = 1; pressed = '0; ev_seen = 0;
    pressed[10] = 1;
    #12;
    check_reset_values();
    @(negedge clk); #2; rst = 1;

    // Row sequence, frame tick, key A press
    wait_edge(1);  check("row_n1", kp_row, 4'b1110);
    wait_edge(7);  check("row_n7", kp_row, 4'b1110);
    wait_edge(8);  check("row_n8", kp_row, 4'b1101);
    wait_edge(22); check("row_n22", kp_row, 4'b0111);
    wait_edge(28); check("tick_n28", frame_tick, 1'b0);
    wait_edge(29); check("tick_n29", frame_tick, 1'b1); check("row_n29", kp_row, 4'b1110);
    check("no_ev_n29", ev_valid, 1'b0);
    wait_edge(70); check("ks_n70", key_state, 16'h0000);
    wait_edge(71); check("ks_n71", key_state, 16'h0400);
    check("evd_press_A", ev_data, 5'b1_1010);
    #2; pressed[10] = 0;
    wait_edge(72); check("ev_pop_n72", ev_valid, 1'b0);
    wait_edge(154); check("ks_n154", key_state, 16'h0400);
    wait_edge(155); check("evd_rel_A", ev_data, 5'b0_1010);

    // Bounce on key 0
    wait_edge(176); #2; pressed[0] = 1; ev_seen = 0;
    wait_edge(232); #2; pressed[0] = 0;
    wait_edge(260); #2; pressed[0] = 1;
    wait_edge(343); check("ks0_n343", key_state[0], 1'b0);
    wait_edge(344); check("ks0_n344", key_state[0], 1'b1);
    check("evd_press_0", ev_data, 5'b1_0000);
    #2; pressed[0] = 0;
    wait_edge(427); check("bounce_events", ev_seen, 1);

    // Overflow with five keys and no consumer
    wait_edge(449); #2; ev_ready = 0;
    pressed[7] = 1; pressed[4] = 1; pressed[1] = 1; pressed[8] = 1; pressed[5] = 1;
    wait_edge(516); check("ovf_n516", overflow, 1'b0);
    wait_edge(517); check("ovf_n517", overflow, 1'b1);
    wait_edge(520); check("head_n520", ev_data, 5'b1_0111);
    #2; ev_ready = 1;
    wait_edge(521); check("head_n521", ev_data, 5'b1_0100);
    wait_edge(522); check("head_n522", ev_data, 5'b1_0001);
    wait_edge(523); check("head_n523", ev_data, 5'b1_1000);
    wait_edge(524); check("drained", ev_valid, 1'b0); check("ovf_sticky", overflow, 1'b1);

    // Async reset mid-scan, then push+pop on a full FIFO
    #2; ev_ready = 0; rst = 0;
    #1; check_reset_values();
    @(negedge clk); #2; rst = 1;
    wait_edge(68); check("full_head", ev_data, 5'b1_0111); check("full_ovf", overflow, 1'b0);
    #2; ev_ready = 1;
    wait_edge(69); check("pp_head", ev_data, 5'b1_0100); check("pp_ovf", overflow, 1'b0);
    wait_edge(70); check("pp_n70", ev_data, 5'b1_0001);
    wait_edge(71); check("pp_n71", ev_data, 5'b1_1000);
    wait_edge(72); check("pp_tail", ev_data, 5'b1_0101);
    wait_edge(73); check("pp_empty", ev_valid, 1'b0);
    #2; pressed = '0;

    // enable drop mid-row 2 with key 8 counter at 2
    wait_edge(197); #2; pressed[8] = 1;
    wait_edge(240); #2; enable = 0;
    wait_edge(241); check("dis_row", kp_row, 4'hF);
    wait_edge(245); #2; enable = 1;
    wait_edge(246); check("reen_row", kp_row, 4'b1110);
    wait_edge(285); check("k8_n285", key_state[8], 1'b0);
    wait_edge(313); check("k8_n313", key_state, 16'h0100);
    check("evd_press_8", ev_data, 5'b1_1000);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      if ($urandom_range(0, 39) == 0) begin
        idx = $urandom_range(0, 15);
        pressed[idx] = ~pressed[idx];
      end
      ev_ready = (i >= 500 && i < 1100) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1;
      if (i == 1800) rst = 0;
      if (i == 1803) rst = 1;
    end
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
